// File: rtl/calc_pkg.sv
// calc_pkg: key codes, operator/state encodings and decimal range helpers
// shared by the parametrised keypad calculator.
package calc_pkg;

  localparam logic [3:0] KEY_PLUS  = 4'hA;
  localparam logic [3:0] KEY_MINUS = 4'hB;
  localparam logic [3:0] KEY_MUL   = 4'hC;
  localparam logic [3:0] KEY_DIV   = 4'hD;
  localparam logic [3:0] KEY_CLR   = 4'hE;
  localparam logic [3:0] KEY_EQ    = 4'hF;

  typedef enum logic [1:0] {PLUS, MINUS, MUL, DIV} op_t;

  typedef enum logic [2:0] {IDLE, DIGIT, OPKEY, CALC, DIVIDE, DISP, ERROR} state_t;

  function automatic int pow10(input int n);
    int v;
    v = 1;
    for (int i = 0; i < n; i++) v = v * 10;
    return v;
  endfunction

  // Largest magnitude that fits in the display digits.
  function automatic int calc_maxv(input int digits);
    return pow10(digits) - 1;
  endfunction

endpackage

// File: rtl/calc_divider.sv
// calc_divider: restoring unsigned divider producing one quotient bit per clock;
// the start cycle already performs the first step so the result lands after WIDTH cycles.
module calc_divider #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, quo_q, dsr_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_in, quo_in, dsr_in, rem_nx, quo_nx;
  logic [WIDTH:0]   shifted;

  // Remainder stays below the divisor, so WIDTH bits always hold it after the trial subtract.
  always_comb begin
    rem_in  = start ? '0 : rem_q;
    quo_in  = start ? dividend : quo_q;
    dsr_in  = start ? divisor : dsr_q;
    shifted = {rem_in, quo_in[WIDTH-1]};
    quo_nx  = {quo_in[WIDTH-2:0], 1'b0};
    rem_nx  = shifted[WIDTH-1:0];
    if (shifted >= {1'b0, dsr_in}) begin
      rem_nx    = WIDTH'(shifted - {1'b0, dsr_in});
      quo_nx[0] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        dsr_q <= divisor;
        cnt_q <= CW'(WIDTH - 1);
      end else if (cnt_q != '0) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) done <= 1'b1;
      end
    end
  end

  assign quotient = quo_q;

endmodule

// File: rtl/calc_core_param.sv
// calc_core_param: signed four-function accumulator calculator driven by keypad
// events, with a sequential divider and a latched overflow/divide-by-zero error.
module calc_core_param
  import calc_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int WIDTH  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic             key_ready,
  output logic [WIDTH-1:0] disp_value,
  output logic             disp_neg,
  output logic             err,
  output logic             busy
);

  localparam int MAXV    = calc_maxv(DIGITS);
  localparam int ARG_LIM = pow10(DIGITS - 1);
  localparam int RW      = WIDTH + 1;
  localparam int SW      = WIDTH + 2;
  localparam int PW      = 2 * WIDTH + 2;
  localparam logic [PW-1:0]    MAXV_P  = PW'(MAXV);
  localparam logic [WIDTH-1:0] ARG_LIM_W = WIDTH'(ARG_LIM);

  generate
    if ((2 ** WIDTH) <= MAXV) begin : g_width_check
      $error("calc_core_param: WIDTH cannot hold 10^DIGITS-1");
    end
  endgenerate

  state_t                 state;
  op_t                    op, next_op;
  logic [WIDTH-1:0]       arg;
  logic signed [RW-1:0]   result;
  logic                   eq_done, is_eq, disp_from_arg;
  logic [3:0]             digit;

  logic                   accept, div_start, div_done, calc_over;
  logic [WIDTH-1:0]       quotient, res_mag, arg_next;
  logic signed [SW-1:0]   sum, diff;
  logic signed [PW-1:0]   prod, calc_val;
  logic [PW-1:0]          calc_mag;
  logic signed [RW-1:0]   div_signed;

  assign accept    = key_valid && key_ready;
  assign div_start = (state == CALC) && (op == DIV) && (arg != '0);

  // Arithmetic is evaluated wide enough that the range check sees the true value.
  always_comb begin
    sum      = SW'(result) + SW'($signed({1'b0, arg}));
    diff     = SW'(result) - SW'($signed({1'b0, arg}));
    prod     = PW'(result) * PW'($signed({1'b0, arg}));
    calc_val = prod;
    case (op)
      PLUS:    calc_val = PW'(sum);
      MINUS:   calc_val = PW'(diff);
      default: calc_val = prod;
    endcase
    calc_mag   = calc_val[PW-1] ? -calc_val : calc_val;
    calc_over  = calc_mag > MAXV_P;
    res_mag    = result[RW-1] ? WIDTH'(-result) : WIDTH'(result);
    div_signed = result[RW-1] ? -$signed({1'b0, quotient}) : $signed({1'b0, quotient});
    arg_next   = WIDTH'(arg * WIDTH'(10) + WIDTH'(digit));
  end

  calc_divider #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (res_mag),
    .divisor  (arg),
    .done     (div_done),
    .quotient (quotient)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      op            <= PLUS;
      next_op       <= PLUS;
      arg           <= '0;
      result        <= '0;
      eq_done       <= 1'b0;
      is_eq         <= 1'b0;
      digit         <= '0;
      disp_from_arg <= 1'b0;
      key_ready     <= 1'b1;
      disp_value    <= '0;
      disp_neg      <= 1'b0;
      err           <= 1'b0;
      busy          <= 1'b0;
    end else if (accept && key_code == KEY_CLR) begin
      state         <= IDLE;
      op            <= PLUS;
      next_op       <= PLUS;
      arg           <= '0;
      result        <= '0;
      eq_done       <= 1'b0;
      is_eq         <= 1'b0;
      digit         <= '0;
      disp_from_arg <= 1'b0;
      key_ready     <= 1'b1;
      disp_value    <= '0;
      disp_neg      <= 1'b0;
      err           <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            key_ready <= 1'b0;
            if (key_code <= 4'd9) begin
              digit <= key_code;
              state <= DIGIT;
            end else begin
              is_eq <= (key_code == KEY_EQ);
              state <= OPKEY;
              case (key_code)
                KEY_MINUS:        next_op <= MINUS;
                KEY_MUL:          next_op <= MUL;
                KEY_DIV:          next_op <= DIV;
                KEY_PLUS, KEY_EQ: next_op <= PLUS;
                default:          next_op <= PLUS;
              endcase
            end
          end
        end
        DIGIT: begin
          if (eq_done) begin
            result  <= '0;
            eq_done <= 1'b0;
          end
          if (arg < ARG_LIM_W) arg <= arg_next;
          disp_from_arg <= 1'b1;
          state         <= DISP;
        end
        OPKEY: state <= CALC;
        CALC: begin
          if ((op == DIV && arg == '0) || (op != DIV && calc_over)) begin
            state      <= ERROR;
            err        <= 1'b1;
            disp_value <= '0;
            disp_neg   <= 1'b0;
            key_ready  <= 1'b1;
          end else begin
            op            <= next_op;
            arg           <= '0;
            eq_done       <= is_eq;
            disp_from_arg <= 1'b0;
            if (op == DIV) begin
              busy  <= 1'b1;
              state <= DIVIDE;
            end else begin
              result <= RW'(calc_val);
              state  <= DISP;
            end
          end
        end
        DIVIDE: begin
          if (div_done) begin
            result <= div_signed;
            busy   <= 1'b0;
            state  <= DISP;
          end
        end
        DISP: begin
          disp_value <= disp_from_arg ? arg : res_mag;
          disp_neg   <= !disp_from_arg && result[RW-1] && (res_mag != '0);
          key_ready  <= 1'b1;
          state      <= IDLE;
        end
        ERROR: state <= ERROR;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
